// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM; outputs decode from state and are held low during reset.
// Optional memory-access timeout trap is enabled by defining CTRL_MEM_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       ir_wren,
  output logic       pc_wren,
  output logic [1:0] pc_src,
  output logic       regfile_wren,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_UPPER    = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_WAIT = 4'd6,
    S_WB_LOAD  = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  state_t     state_r;
  state_t     state_s;
  state_t     nxt_s;
  logic       tmo_hit_s;
  logic       ir_wren_s;
  logic       pc_wren_s;
  logic [1:0] pc_src_s;
  logic       regfile_wren_s;
  logic [1:0] wb_sel_s;
  logic       alu_a_sel_s;
  logic       alu_b_sel_s;
  logic       mem_req_s;
  logic       mem_we_s;
  logic       mem_addr_sel_s;
  logic       illegal_s;

  // Configuration sanity guard; a bad parameter set elaborates this empty marker block.
  if (WIDTH < 1 || MEM_TIMEOUT < 1) begin : g_cfg_invalid
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and output decode.
  always_comb begin
    nxt_s          = state_r;
    ir_wren_s      = 1'b0;
    pc_wren_s      = 1'b0;
    pc_src_s       = 2'd0;
    regfile_wren_s = 1'b0;
    wb_sel_s       = 2'd0;
    alu_a_sel_s    = 1'b0;
    alu_b_sel_s    = 1'b0;
    mem_req_s      = 1'b0;
    mem_we_s       = 1'b0;
    mem_addr_sel_s = 1'b0;
    illegal_s      = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_wren_s = 1'b1;
          pc_wren_s = 1'b1;
          nxt_s     = S_DECODE;
        end else begin
          nxt_s     = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              nxt_s = S_EXEC_R;
          OP_I:              nxt_s = S_EXEC_I;
          OP_LOAD, OP_STORE: nxt_s = S_MEM_ADDR;
          OP_BR:             nxt_s = S_BRANCH;
          OP_JAL, OP_JALR:   nxt_s = S_JUMP;
          OP_LUI, OP_AUIPC:  nxt_s = S_UPPER;
          default:           nxt_s = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        regfile_wren_s = 1'b1;
        nxt_s          = S_FETCH;
      end
      S_EXEC_I: begin
        regfile_wren_s = 1'b1;
        alu_b_sel_s    = 1'b1;
        nxt_s          = S_FETCH;
      end
      S_UPPER: begin
        regfile_wren_s = 1'b1;
        if (opcode == OP_LUI) begin
          wb_sel_s    = 2'd3;
        end else begin
          alu_a_sel_s = 1'b1;
          alu_b_sel_s = 1'b1;
        end
        nxt_s = S_FETCH;
      end
      // Address phase and wait phase drive identical memory controls.
      S_MEM_ADDR, S_MEM_WAIT: begin
        alu_b_sel_s    = 1'b1;
        mem_addr_sel_s = 1'b1;
        mem_req_s      = 1'b1;
        mem_we_s       = (opcode == OP_STORE);
        if (!mem_ready) begin
          nxt_s = S_MEM_WAIT;
        end else if (opcode == OP_STORE) begin
          nxt_s = S_FETCH;
        end else begin
          nxt_s = S_WB_LOAD;
        end
      end
      S_WB_LOAD: begin
        regfile_wren_s = 1'b1;
        wb_sel_s       = 2'd1;
        nxt_s          = S_FETCH;
      end
      S_BRANCH: begin
        if (branch_taken) begin
          pc_wren_s = 1'b1;
          pc_src_s  = 2'd1;
        end else begin
          pc_wren_s = 1'b0;
        end
        nxt_s = S_FETCH;
      end
      S_JUMP: begin
        regfile_wren_s = 1'b1;
        wb_sel_s       = 2'd2;
        pc_wren_s      = 1'b1;
        pc_src_s       = (opcode == OP_JAL) ? 2'd1 : 2'd2;
        nxt_s          = S_FETCH;
      end
      S_TRAP: begin
        illegal_s = 1'b1;
        nxt_s     = S_TRAP;
      end
      default: begin
        nxt_s = S_TRAP;
      end
    endcase
  end

  assign state_s = tmo_hit_s ? S_TRAP : nxt_s;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt_r;
  logic             mem_stall_s;

  assign mem_stall_s = ((state_r == S_FETCH) || (state_r == S_MEM_ADDR) ||
                        (state_r == S_MEM_WAIT)) && !mem_ready;
  // The stall that brings the run of consecutive stalls up to MEM_TIMEOUT traps.
  assign tmo_hit_s   = mem_stall_s && (tmo_cnt_r == CNT_W'(MEM_TIMEOUT - 1));

  // Consecutive-stall counter; restarts on any progress or state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
    end else if (!mem_stall_s || (state_s != state_r)) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  assign ir_wren      = ir_wren_s & rst_n;
  assign pc_wren      = pc_wren_s & rst_n;
  assign pc_src       = pc_src_s & {2{rst_n}};
  assign regfile_wren = regfile_wren_s & rst_n;
  assign wb_sel       = wb_sel_s & {2{rst_n}};
  assign alu_a_sel    = alu_a_sel_s & rst_n;
  assign alu_b_sel    = alu_b_sel_s & rst_n;
  assign mem_req      = mem_req_s & rst_n;
  assign mem_we       = mem_we_s & rst_n;
  assign mem_addr_sel = mem_addr_sel_s & rst_n;
  assign illegal      = illegal_s & rst_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle output vectors; a single negedge process compares the DUT to them.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  // Output vector bits: {ir, pcw, pc_src[1:0], rfw, wb_sel[1:0], a_sel, b_sel, req, we, addr_sel, illegal}
  localparam logic [12:0] O_IR   = 13'h1000;
  localparam logic [12:0] O_PCW  = 13'h0800;
  localparam logic [12:0] O_PCS1 = 13'h0200;
  localparam logic [12:0] O_PCS2 = 13'h0400;
  localparam logic [12:0] O_RFW  = 13'h0100;
  localparam logic [12:0] O_WB1  = 13'h0040;
  localparam logic [12:0] O_WB2  = 13'h0080;
  localparam logic [12:0] O_WB3  = 13'h00C0;
  localparam logic [12:0] O_A    = 13'h0020;
  localparam logic [12:0] O_B    = 13'h0010;
  localparam logic [12:0] O_REQ  = 13'h0008;
  localparam logic [12:0] O_WE   = 13'h0004;
  localparam logic [12:0] O_ASEL = 13'h0002;
  localparam logic [12:0] O_ILL  = 13'h0001;

  typedef struct packed {
    logic        rdy;
    logic [6:0]  op;
    logic        bt;
    logic [12:0] exp;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_wren, pc_wren, regfile_wren, alu_a_sel, alu_b_sel;
  logic        mem_req, mem_we, mem_addr_sel, illegal;
  logic [1:0]  pc_src, wb_sel;
  logic [12:0] act;

  ent_t        sched[$];
  logic [12:0] exp = 13'd0;
  bit          chk_en = 1'b0;
  bit          pin_en = 1'b0;
  int          pin_act = 0;
  int          pin_exp = 0;
  string       tag = "init";
  string       pin_tag = "";
  int          vec_idx = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          n0 = 0;

  multicycle_ctrl #(.WIDTH(32), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .ir_wren(ir_wren), .pc_wren(pc_wren), .pc_src(pc_src),
    .regfile_wren(regfile_wren), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .illegal(illegal)
  );

  assign act = {ir_wren, pc_wren, pc_src, regfile_wren, wb_sel, alu_a_sel, alu_b_sel,
                mem_req, mem_we, mem_addr_sel, illegal};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s vec %0d: outputs got %h expected %h", tag, vec_idx, act, exp);
      end
    end
    if (pin_en) begin
      n_vec++;
      if (pin_act != pin_exp) begin
        n_bad++;
        $display("FAIL model_%s: got %h expected %h", pin_tag, pin_act, pin_exp);
      end
    end
  end

  task automatic push(input logic r, input logic [6:0] o, input logic b, input logic [12:0] x);
    ent_t e;
    e.rdy = r; e.op = o; e.bt = b; e.exp = x;
    sched.push_back(e);
  endtask

  // Expand one instruction into its expected cycles; for an illegal opcode, mstall is the
  // number of TRAP cycles to observe. The opcode bus carries junk during fetch.
  task automatic add_instr(input logic [6:0] op, input logic bt, input int fstall, input int mstall);
    logic [12:0] mem_o;
    for (int i = 0; i < fstall; i++) push(1'b0, OP_BAD, ~bt, O_REQ);
    push(1'b1, OP_BAD, ~bt, O_IR | O_PCW | O_REQ);
    push(1'b1, op, bt, 13'h0);
    case (op)
      OP_R:     push(1'b1, op, bt, O_RFW);
      OP_I:     push(1'b0, op, bt, O_RFW | O_B);
      OP_LUI:   push(1'b1, op, bt, O_RFW | O_WB3);
      OP_AUIPC: push(1'b0, op, bt, O_RFW | O_A | O_B);
      OP_LOAD, OP_STORE: begin
        mem_o = O_B | O_ASEL | O_REQ | ((op == OP_STORE) ? O_WE : 13'h0);
        for (int i = 0; i < mstall; i++) push(1'b0, op, bt, mem_o);
        push(1'b1, op, bt, mem_o);
        if (op == OP_LOAD) push(1'b0, op, bt, O_RFW | O_WB1);
      end
      OP_BR:    push(1'b1, op, bt, bt ? (O_PCW | O_PCS1) : 13'h0);
      OP_JAL:   push(1'b0, op, bt, O_RFW | O_WB2 | O_PCW | O_PCS1);
      OP_JALR:  push(1'b1, op, bt, O_RFW | O_WB2 | O_PCW | O_PCS2);
      default: begin
        for (int i = 0; i < mstall; i++) begin
          logic [1:0] ib;
          ib = i[1:0];
          push(ib[0], op, ib[1], O_ILL);
        end
      end
    endcase
  endtask

  task automatic pin(input string nm, input int a, input int e);
    pin_tag = nm; pin_act = a; pin_exp = e; pin_en = 1'b1;
    @(negedge clk); #1;
    pin_en = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_LOAD; branch_taken = 1'b1;
    exp = 13'h0; tag = nm; vec_idx = 0; chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic run_sched(input string nm);
    ent_t e;
    bit   first;
    first = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tag = nm; vec_idx = 0;
    while (sched.size() > 0) begin
      e = sched.pop_front();
      if (!first) begin
        @(posedge clk); #1;
      end
      first = 1'b0;
      mem_ready = e.rdy; opcode = e.op; branch_taken = e.bt; exp = e.exp;
      chk_en = 1'b1; vec_idx++;
    end
    @(negedge clk); #1;
    chk_en = 1'b0;
  endtask

  initial begin
    // Phase 1: every instruction class back to back, including stalls on both memory ports.
    do_reset("reset");
    n0 = sched.size(); add_instr(OP_R, 1'b0, 0, 0);
    pin("r_len", sched.size() - n0, 3);
    pin("r_fetch", int'(sched[n0].exp), 32'h1808);
    pin("r_exec", int'(sched[n0+2].exp), 32'h0100);
    add_instr(OP_I, 1'b1, 2, 0);
    add_instr(OP_LUI, 1'b0, 0, 0);
    add_instr(OP_AUIPC, 1'b1, 1, 0);
    n0 = sched.size(); add_instr(OP_STORE, 1'b0, 0, 0);
    pin("store_len", sched.size() - n0, 3);
    add_instr(OP_STORE, 1'b1, 0, 2);
    n0 = sched.size(); add_instr(OP_LOAD, 1'b0, 0, 0);
    pin("load_len", sched.size() - n0, 4);
    n0 = sched.size(); add_instr(OP_LOAD, 1'b0, 0, 3);
    pin("load_wait_len", sched.size() - n0, 7);
    pin("load_wb", int'(sched[n0+6].exp), 32'h0140);
    add_instr(OP_BR, 1'b0, 0, 0);
    n0 = sched.size(); add_instr(OP_BR, 1'b1, 0, 0);
    pin("br_taken", int'(sched[n0+2].exp), 32'h0A00);
    add_instr(OP_JAL, 1'b0, 0, 0);
    n0 = sched.size(); add_instr(OP_JALR, 1'b0, 0, 0);
    pin("jalr_exec", int'(sched[n0+2].exp), 32'h0D80);
    add_instr(OP_R, 1'b1, 0, 0);
    run_sched("seq");

    // Phase 2: illegal opcode traps and stays trapped for 100 cycles.
    do_reset("reset_pre_trap");
    n0 = sched.size(); add_instr(OP_BAD, 1'b0, 0, 100);
    pin("trap_len", sched.size() - n0, 102);
    run_sched("trap");

    // Phase 3: reset taken from TRAP clears illegal within the same cycle; machine then restarts.
    do_reset("reset_from_trap");
    add_instr(OP_JALR, 1'b1, 0, 0);
    add_instr(OP_LOAD, 1'b1, 2, 1);
    run_sched("after_trap");

    // Phase 4: fetch that never completes.
    do_reset("reset_pre_stall");
`ifdef CTRL_MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) push(1'b0, OP_BAD, 1'b0, O_REQ);
    for (int i = 0; i < 5; i++) push(1'b0, OP_R, 1'b0, O_ILL);
    run_sched("timeout");
`else
    add_instr(OP_R, 1'b0, 1000, 0);
    run_sched("long_stall");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
